// File: rtl/top_if.sv
// Handshake bundle between the host and the cascaded matrix-multiply block.
//
// Handshake semantics (all sampled on the rising clock edge):
//   init_valid  (host)  : held high to request a weight burst; a beat is
//                         captured on every cycle where init_ready (block) is
//                         high, regardless of init_valid at that time.
//   start_valid (block) : high while idle with weights loaded; a run begins on
//                         a cycle where start_valid and start_ready (host) are
//                         both high. Input beats are captured on every cycle
//                         where load_ready (block) is high.
//   result_valid (block): high on each cycle carrying a result beat; the host
//                         has no back-pressure and must take every beat.
interface top_if;
  logic        init_valid;
  logic        init_ready;
  logic        start_ready;
  logic        start_valid;
  logic        load_ready;
  logic [31:0] load_payload;
  logic        result_valid;
  logic [31:0] result_payload;

  modport master (
    output init_valid, start_ready, load_payload,
    input  init_ready, start_valid, load_ready, result_valid, result_payload
  );

  modport slave (
    input  init_valid, start_ready, load_payload,
    output init_ready, start_valid, load_ready, result_valid, result_payload
  );
endinterface

// File: rtl/top.sv
// Cascade of LAYER_N fixed-point N x N matrix multiplies: Y_{l+1} = W_l x Y_l.
// Weights are held in a row-wide store; one output element is produced per
// cycle by N parallel MACs feeding an adder tree, written to a shadow buffer
// and copied back to the working buffer at the end of each layer.
module top #(
  parameter int LAYER_N = 8,
  parameter int N       = 16,
  parameter int DW      = 16,
  parameter int FRAC    = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  top_if.slave       bus,
  output logic [2:0] dbg_state
);

  localparam int NB    = $clog2(N);
  localparam int WA_W  = $clog2(LAYER_N * N);
  localparam int CW    = $clog2(LAYER_N * N * N / 2) + 1;
  localparam int LW    = (LAYER_N > 1) ? $clog2(LAYER_N) : 1;
  localparam int ACC_W = 2 * DW + NB + 8;

  localparam logic [CW-1:0] INIT_LAST  = CW'(LAYER_N * N * N / 2 - 1);
  localparam logic [CW-1:0] XFER_LAST  = CW'(N * N / 2 - 1);
  localparam logic [CW-1:0] COPY_CYC   = CW'(N * N);
  localparam logic [LW-1:0] LAYER_LAST = LW'(LAYER_N - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DW - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DW - 1)));

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_WAIT = 3'd1,
    INIT_LOAD = 3'd2,
    IN_WAIT1  = 3'd3,
    IN_WAIT2  = 3'd4,
    IN_LOAD   = 3'd5,
    COMPUTE   = 3'd6,
    OUTPUT    = 3'd7
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   layer;
  logic            weights_loaded;

  // Row r of layer l lives at wmem[{l, r}], columns packed low to high.
  logic [N*DW-1:0]        wmem  [LAYER_N*N];
  logic signed [DW-1:0]   ycur  [N*N];
  logic signed [DW-1:0]   ynext [N*N];

  logic [N*DW-1:0]        wrow;
  logic [NB-1:0]          col;
  logic [2*NB-1:0]        yidx;
  logic signed [DW-1:0]   wa, yb;
  logic signed [2*DW-1:0] prod;
  logic signed [ACC_W-1:0] acc, shifted;
  logic signed [DW-1:0]   sat_val;

  // Input beat p/c layout and output beat p/c layout differ (row-pair inner on output).
  logic [2*NB-1:0] in_lo, in_hi, out_lo, out_hi;
  assign in_lo  = {cnt[2*NB-2:NB], 1'b0, cnt[NB-1:0]};
  assign in_hi  = {cnt[2*NB-2:NB], 1'b1, cnt[NB-1:0]};
  assign out_lo = {cnt[NB-2:0], 1'b0, cnt[2*NB-2:NB-1]};
  assign out_hi = {cnt[NB-2:0], 1'b1, cnt[2*NB-2:NB-1]};

  // State register; reset aborts any burst or run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; init requests win over start requests in IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.init_valid)                           state_next = INIT_WAIT;
        else if (bus.start_ready && weights_loaded)   state_next = IN_WAIT1;
      end
      INIT_WAIT: state_next = INIT_LOAD;
      INIT_LOAD: if (cnt == INIT_LAST) state_next = IDLE;
      IN_WAIT1:  state_next = IN_WAIT2;
      IN_WAIT2:  state_next = IN_LOAD;
      IN_LOAD:   if (cnt == XFER_LAST) state_next = COMPUTE;
      COMPUTE:   if (cnt == COPY_CYC && layer == LAYER_LAST) state_next = OUTPUT;
      OUTPUT:    if (cnt == XFER_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Beat/element counter, layer index and weights-loaded flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      layer          <= '0;
      weights_loaded <= 1'b0;
    end else begin
      if (state_next != state)
        cnt <= '0;
      else if (state == COMPUTE && cnt == COPY_CYC)
        cnt <= '0;
      else if (state == INIT_LOAD || state == IN_LOAD || state == COMPUTE || state == OUTPUT)
        cnt <= cnt + CW'(1);

      if (state != COMPUTE)        layer <= '0;
      else if (cnt == COPY_CYC)    layer <= layer + LW'(1);

      if (state == INIT_LOAD && cnt == INIT_LAST) weights_loaded <= 1'b1;
    end
  end

  // One output element per cycle: N MACs, full-precision sum, floor shift, saturate.
  always_comb begin
    wrow = wmem[{layer, cnt[2*NB-1:NB]}];
    col  = cnt[NB-1:0];
    acc  = '0;
    prod = '0;
    wa   = '0;
    yb   = '0;
    yidx = '0;
    for (int k = 0; k < N; k++) begin
      yidx = {NB'(k), col};
      wa   = wrow[k*DW +: DW];
      yb   = ycur[yidx];
      prod = (2*DW)'(wa) * (2*DW)'(yb);
      acc  = acc + ACC_W'(prod);
    end
    shifted = acc >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = {1'b0, {(DW-1){1'b1}}};
    else if (shifted < SAT_MIN) sat_val = {1'b1, {(DW-1){1'b0}}};
    else                        sat_val = shifted[DW-1:0];
  end

  // Storage writes: weight beats, input beats, layer results and end-of-layer copy.
  always_ff @(posedge clk) begin
    if (state == INIT_LOAD)
      wmem[cnt[NB-1 +: WA_W]][int'(cnt[NB-2:0]) * 2 * DW +: 2 * DW] <= bus.load_payload;
    if (state == IN_LOAD) begin
      ycur[in_lo] <= bus.load_payload[DW-1:0];
      ycur[in_hi] <= bus.load_payload[2*DW-1:DW];
    end
    if (state == COMPUTE) begin
      if (cnt == COPY_CYC) ycur <= ynext;
      else                 ynext[cnt[2*NB-1:0]] <= sat_val;
    end
  end

  assign bus.init_ready     = (state == INIT_LOAD);
  assign bus.load_ready     = (state == IN_LOAD);
  assign bus.result_valid   = (state == OUTPUT);
  assign bus.start_valid    = (state == IDLE) && weights_loaded;
  assign bus.result_payload = (state == OUTPUT) ? {ycur[out_hi], ycur[out_lo]} : '0;
  assign dbg_state          = state;

endmodule

// File: tb/tb_top.sv
// Bench for the cascaded matrix-multiply block: drives weight and input
// bursts, predicts results with an independent integer model and compares
// every result beat through an expected queue.
module tb_top;
  localparam int LAYER_N = 8;
  localparam int N       = 16;
  localparam int DW      = 16;
  localparam int FRAC    = 9;
  localparam int BEATS_W = LAYER_N * N * N / 2;
  localparam int BEATS_X = N * N / 2;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COMPUTE = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  top_if bus();
  logic [2:0] dbg_state;

  top #(.LAYER_N(LAYER_N), .N(N), .DW(DW), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  int wm[LAYER_N][N][N];
  int xm[N][N];
  int run_len    = 0;
  int idle_dirty = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model_push();
    int y[N][N];
    int t[N][N];
    longint acc;
    y = xm;
    for (int l = 0; l < LAYER_N; l++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc = 0;
          for (int k = 0; k < N; k++)
            acc += longint'(wm[l][i][k]) * longint'(y[k][j]);
          t[i][j] = sat16(acc >>> FRAC);
        end
      y = t;
    end
    for (int c = 0; c < N; c++)
      for (int p = 0; p < N / 2; p++)
        exp_q.push_back({16'(y[2*p+1][c]), 16'(y[2*p][c])});
  endfunction

  function automatic void set_weights(input int mode);
    for (int l = 0; l < LAYER_N; l++)
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          case (mode)
            0:       wm[l][r][c] = 0;
            1:       wm[l][r][c] = (r == c) ? 512 : 0;
            2:       wm[l][r][c] = (r == c) ? 1024 : 0;
            default: wm[l][r][c] = int'($urandom_range(0, 400)) - 200;
          endcase
  endfunction

  function automatic void set_inputs(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        case (mode)
          0:       xm[r][c] = r + c;
          1:       xm[r][c] = 512;
          2:       xm[r][c] = -512;
          default: xm[r][c] = int'($urandom_range(0, 16383)) - 8192;
        endcase
  endfunction

  // ---------------- result monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && bus.result_valid) begin
      run_len++;
      check("result_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("result_beat", bus.result_payload, exp_q.pop_front());
    end else begin
      if (run_len != 0) begin
        check("result_run_len", 32'(run_len), 32'd128);
        run_len = 0;
      end
      if (bus.result_payload !== 32'd0) idle_dirty++;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_init(input bit also_start, input bit drop_early);
    int waited;
    int bad;
    int l, r, k;
    @(posedge clk); #1;
    bus.init_valid = 1'b1;
    if (also_start) bus.start_ready = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus.init_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("init_ready_latency", 32'(waited), 32'd2);
    bus.start_ready = 1'b0;
    bad = 0;
    for (int b = 0; b < BEATS_W; b++) begin
      l = b / (N * N / 2);
      r = (b / (N / 2)) % N;
      k = b % (N / 2);
      if (!bus.init_ready) bad++;
      bus.load_payload = {16'(wm[l][r][2*k+1]), 16'(wm[l][r][2*k])};
      if (drop_early || b == BEATS_W - 1) bus.init_valid = 1'b0;
      @(negedge clk);
    end
    bus.load_payload = $urandom;
    check("init_ready_gaps", 32'(bad), 32'd0);
    check("init_ready_end", 32'(bus.init_ready), 32'd0);
    check("start_valid_after_init", 32'(bus.start_valid), 32'd1);
  endtask

  // xmode < 0 keeps the previous input matrix; abort resets mid-COMPUTE.
  task automatic send_run(input int xmode, input bit abort);
    int waited;
    int bad;
    int lat;
    int p, c;
    if (xmode >= 0) set_inputs(xmode);
    if (!abort) model_push();
    waited = 0;
    @(negedge clk);
    while (!bus.start_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("start_valid_before_run", 32'(bus.start_valid), 32'd1);
    bus.start_ready = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.load_ready && waited < 10);
    check("load_ready_latency", 32'(waited), 32'd3);
    bad = 0;
    for (int b = 0; b < BEATS_X; b++) begin
      p = b / N;
      c = b % N;
      if (!bus.load_ready) bad++;
      bus.load_payload = {16'(xm[2*p+1][c]), 16'(xm[2*p][c])};
      if (b == 0) bus.start_ready = 1'b0;
      @(negedge clk);
    end
    bus.load_payload = $urandom;
    check("load_ready_gaps", 32'(bad), 32'd0);
    check("load_ready_end", 32'(bus.load_ready), 32'd0);
    if (abort) begin
      repeat (100) @(negedge clk);
      check("state_in_compute", 32'(dbg_state), 32'(ST_COMPUTE));
      rst_n = 1'b0;
      #2;
      check("abort_outputs_zero",
            {bus.init_ready, bus.start_valid, bus.load_ready, bus.result_valid, bus.result_payload},
            32'd0);
      check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_start_valid_low", 32'(bus.start_valid), 32'd0);
      bus.start_ready = 1'b1;
      repeat (3) @(negedge clk);
      bus.start_ready = 1'b0;
      check("abort_start_ignored_state", 32'(dbg_state), 32'(ST_IDLE));
      check("abort_start_ignored_load", 32'(bus.load_ready), 32'd0);
    end else begin
      lat = 0;
      while (!bus.result_valid && lat < 9000) begin
        @(negedge clk);
        lat++;
      end
      check("result_latency_ok", 32'(lat <= 8192), 32'd1);
      waited = 0;
      while ((exp_q.size() != 0 || bus.result_valid) && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      @(negedge clk);
      check("result_queue_drained", 32'(exp_q.size()), 32'd0);
      check("state_idle_after_run", 32'(dbg_state), 32'(ST_IDLE));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.init_valid   = 1'b0;
    bus.start_ready  = 1'b0;
    bus.load_payload = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.init_ready, bus.start_valid, bus.load_ready, bus.result_valid, bus.result_payload},
          32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    // Start request with no weights loaded must be ignored.
    bus.start_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.start_ready = 1'b0;
    check("start_without_weights", 32'(dbg_state), 32'(ST_IDLE));

    set_weights(1); send_init(1'b0, 1'b0); send_run(0, 1'b0);
    set_weights(0); send_init(1'b0, 1'b1); send_run(3, 1'b0);
    set_weights(2); send_init(1'b0, 1'b0); send_run(1, 1'b0); send_run(2, 1'b0);
    set_weights(3); send_init(1'b1, 1'b1);
    check("init_over_start_no_load", 32'(bus.load_ready), 32'd0);
    send_run(3, 1'b0); send_run(-1, 1'b0);
    set_weights(1); send_init(1'b0, 1'b0); send_run(0, 1'b1);
    set_weights(3); send_init(1'b0, 1'b0); send_run(3, 1'b0);

    check("idle_payload_zero", 32'(idle_dirty), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
